// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB bundle into the write-back stage and the register-file
// write port plus debug state coming out of it.
// The optional WB_HIST_EN macro adds the one-deep forwarding history signals.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  // Control from the pipeline
  logic             stall;
  logic             flush;
  // MEM/WB bundle
  logic             mem_to_reg;
  logic             reg_write_in;
  logic [31:0]      read_data;
  logic [31:0]      address_in;
  logic [4:0]       write_back_destination_in;
  logic [1:0]       load_mode_in;
  // Register-file write port and debug state
  logic [4:0]       write_register;
  logic [31:0]      write_data;
  logic             reg_write_out;
  logic             misalign_err;
  logic [CNT_W-1:0] retired_count;
`ifdef WB_HIST_EN
  // Previous cycle's committed write, for the forwarding unit
  logic [4:0]       hist_dest;
  logic [31:0]      hist_data;
  logic             hist_valid;
`endif

  // Upstream side: the MEM stage / pipeline control drives the bundle
  modport master (
    output stall, flush, mem_to_reg, reg_write_in, read_data, address_in,
           write_back_destination_in, load_mode_in,
`ifdef WB_HIST_EN
    input  hist_dest, hist_data, hist_valid,
`endif
    input  write_register, write_data, reg_write_out, misalign_err, retired_count
  );

  // The write-back stage consumes the bundle and drives the write port
  modport slave (
    input  stall, flush, mem_to_reg, reg_write_in, read_data, address_in,
           write_back_destination_in, load_mode_in,
`ifdef WB_HIST_EN
    output hist_dest, hist_data, hist_valid,
`endif
    output write_register, write_data, reg_write_out, misalign_err, retired_count
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage. Aligns and extends loads, selects the
// write-back value, and registers it into the register-file write port with
// one cycle of latency. Also tracks retired writes and a sticky misaligned-load
// flag. Optional macro WB_HIST_EN adds a one-deep committed-write history.
module wb_stage #(
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] RESET_PC_TAG = {CNT_W{1'b0}}
) (
  input  logic       CLK,
  input  logic       RST,
  wb_stage_if.slave  bus
);

  // Load alignment result: bit 32 flags a misaligned access, [31:0] is the
  // extended load value. Byte lanes are little-endian by addr[1:0].
  function automatic logic [32:0] align_load(
    input logic [31:0] raw,
    input logic [1:0]  addr_lo,
    input logic [1:0]  mode
  );
    logic [15:0] half_s;
    logic [7:0]  byte_s;
    logic [32:0] res_s;
    half_s = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (addr_lo)
      2'd0:    byte_s = raw[7:0];
      2'd1:    byte_s = raw[15:8];
      2'd2:    byte_s = raw[23:16];
      2'd3:    byte_s = raw[31:24];
      default: byte_s = 8'd0;
    endcase
    case (mode)
      2'b00:   res_s = {(addr_lo != 2'd0), raw};
      2'b01:   res_s = {addr_lo[0], {16{half_s[15]}}, half_s};
      2'b10:   res_s = {1'b0, {24{byte_s[7]}}, byte_s};
      2'b11:   res_s = {1'b0, 24'd0, byte_s};
      default: res_s = 33'd0;
    endcase
    return res_s;
  endfunction

  // Output registers
  logic [4:0]       wr_reg_q,  wr_reg_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             wr_en_q,   wr_en_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
`ifdef WB_HIST_EN
  logic [4:0]       hist_dest_q;
  logic [31:0]      hist_data_q;
  logic             hist_valid_q;
`endif

  // Intermediate combinational signals
  logic [32:0]      align_s;
  logic             misaligned_s;
  logic             live_s;

  // Next-state: value select, write-enable qualification, flag and counter
  always_comb begin
    align_s      = align_load(bus.read_data, bus.address_in[1:0], bus.load_mode_in);
    misaligned_s = 1'b0;
    wr_data_d    = bus.address_in;
    wr_reg_d     = bus.write_back_destination_in;
    if (bus.mem_to_reg) begin
      misaligned_s = align_s[32];
      wr_data_d    = align_s[31:0];
    end else begin
      misaligned_s = 1'b0;
      wr_data_d    = bus.address_in;
    end
    // A flushed instruction is squashed entirely: no write and no error report
    live_s  = bus.reg_write_in & ~bus.flush;
    wr_en_d = live_s & (bus.write_back_destination_in != 5'd0) & ~misaligned_s;
    err_d   = err_q | (live_s & misaligned_s);
    if (wr_en_d) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register: reset beats stall, stall holds everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= RESET_PC_TAG;
    end else if (!bus.stall) begin
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef WB_HIST_EN
  // History register: captures the write currently on the port each live edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_dest_q  <= 5'd0;
      hist_data_q  <= 32'd0;
      hist_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      hist_dest_q  <= wr_reg_q;
      hist_data_q  <= wr_data_q;
      hist_valid_q <= wr_en_q;
    end
  end

  assign bus.hist_dest  = hist_dest_q;
  assign bus.hist_data  = hist_data_q;
  assign bus.hist_valid = hist_valid_q;
`endif

  assign bus.write_register = wr_reg_q;
  assign bus.write_data     = wr_data_q;
  assign bus.reg_write_out  = wr_en_q;
  assign bus.misalign_err   = err_q;
  assign bus.retired_count  = cnt_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage MIPS pipeline, directly downstream of the MEM stage.
- Consumes the MEM/WB bundle: read data, ALU address/result, mem-to-reg, reg-write, destination, load mode.
- Performs load alignment and sign/zero extension, then selects the write-back value.
- Registers the result into the write port that feeds the ID-stage register file.
- Keeps a retirement counter and a sticky misalignment flag for debug.

Parameters:
CNT_W, 32, width of the retired-write counter.
RESET_PC_TAG, 0, value loaded into the counter on reset.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
stall  input  1  hold all output registers; inputs are ignored
flush  input  1  squash the instruction currently presented
mem_to_reg  input  1  1 = write memory data, 0 = write ALU result
reg_write_in  input  1  instruction writes a register
read_data  input  32  raw 32-bit word from data memory
address_in  input  32  ALU result; also the load address
write_back_destination_in  input  5  destination register number
load_mode_in  input  2  00 word, 01 halfword signed, 10 byte signed, 11 byte unsigned
write_register  output  5  register-file write address
write_data  output  32  register-file write data
reg_write_out  output  1  register-file write enable
misalign_err  output  1  sticky misaligned-load flag
retired_count  output  CNT_W  count of committed register writes

Behaviour:
Reset:
- When RST=1 at a clock edge: write_register=0, write_data=0, reg_write_out=0, misalign_err=0, retired_count=RESET_PC_TAG.
- RST has priority over stall and flush.
- A reset mid-stream discards any in-flight instruction.

Latency and hold:
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- stall=1 with RST=0: every output register, including the counter, holds its value.
- flush=1 with stall=0: next reg_write_out=0 and the counter does not increment. write_register and write_data still load (don't-care).
- stall=1 and flush=1 together: stall wins and the outputs hold.

Load alignment (applies when mem_to_reg=1), byte lanes little-endian by address_in[1:0]:
- 00 word: data = read_data. If address_in[1:0] != 0, the access is misaligned.
- 01 halfword: address_in[1] selects read_data[31:16] (1) or [15:0] (0), then sign-extended. If address_in[0]=1, the access is misaligned.
- 10 byte signed: lane k = read_data[8k+7:8k], sign-extended.
- 11 byte unsigned: the same lane, zero-extended.

Data select:
- mem_to_reg=0: write_data = address_in unmodified. load_mode_in and alignment are ignored.

Write enable:
- reg_write_out = reg_write_in AND (dest != 0) AND not misaligned AND not flush.
- Writes to $0 are always suppressed.

Misalignment:
- A misaligned load with reg_write_in=1 sets misalign_err on that edge.
- misalign_err clears only on RST.

Retired counter:
- Increments by 1 on every edge where the next reg_write_out=1.
- Wraps modulo 2^CNT_W with no saturation.

Optional Feature:
WB_HIST_EN
- Defined: add outputs hist_dest[4:0], hist_data[31:0] and hist_valid for the forwarding unit.
  - Together they form a one-deep history register holding the previous cycle's committed write.
  - On each non-stalled edge the history takes the current write_register, write_data and reg_write_out.
  - Reset clears all three to 0. stall holds them.
- Undefined: these ports and registers do not exist; all other behaviour is unchanged.

Test Plan:
1. Reset: RST=1 for 2 cycles with random inputs -> all outputs 0 and retired_count=0. First instruction after release appears one cycle later.
2. ALU write: mem_to_reg=0, reg_write_in=1, dest=5, address_in=0x1234_5678 -> next cycle write_register=5, write_data=0x12345678, reg_write_out=1, retired_count=1.
3. Byte loads: read_data=0x80FF_7F01, load byte at address_in[1:0]=3, mode 10 then mode 11 -> write_data 0xFFFF_FF80 then 0x0000_0080.
4. Halfword and misalign: mode 01, addr=0x...2 -> write_data 0xFFFF_80FF. Addr=0x...1 -> reg_write_out=0, misalign_err=1, counter unchanged, flag still 1 after 10 cycles.
5. $0 and flush: dest=0 with reg_write_in=1 -> reg_write_out=0. Valid write with flush=1 -> reg_write_out=0. stall+flush together -> outputs unchanged.
6. Stall and wrap: CNT_W=4, 15 valid writes then stall for 3 cycles -> count holds at 15. One more write -> count=0.
